// File: rtl/flag_reg_pkg.sv
// Shared constants and helpers for the status-line synchroniser / event latch.
package flag_reg_pkg;

    localparam int FLAG_MAX_WIDTH = 32;

    // Per-bit 0->1 transition from prev to cur, qualified by mask.
    // Falling edges are obtained by passing inverted prev/cur.
    function automatic logic [FLAG_MAX_WIDTH-1:0] edge_vec(
        input logic [FLAG_MAX_WIDTH-1:0] prev,
        input logic [FLAG_MAX_WIDTH-1:0] cur,
        input logic [FLAG_MAX_WIDTH-1:0] mask
    );
        return ~prev & cur & mask;
    endfunction

endpackage

// File: rtl/flag_reg_sync_chain.sv
// Single-bit multi-stage synchroniser. s[0] is the only flop that samples
// the asynchronous input; q_pre exposes the stage before q so the parent
// can form registered edge pulses that line up with q.
module sync_chain #(
    parameter int   STAGES   = 2,
    parameter logic INIT_BIT = 1'b0
) (
    input  logic clk,
    input  logic clr_n,
    input  logic d,
    output logic q,
    output logic q_pre
);

    if (STAGES < 2) begin : g_bad_stages
        $error("sync_chain: STAGES must be at least 2");
    end

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] s;

    // Shift the raw input through the chain; reset loads the channel's init level.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            s <= {STAGES{INIT_BIT}};
        end else begin
            s <= {s[STAGES-2:0], d};
        end
    end

    assign q     = s[STAGES-1];
    assign q_pre = s[STAGES-2];

endmodule

// File: rtl/flag_reg_sync.sv
// WIDTH-channel synchroniser with registered rise/fall pulses, sticky
// event flags (W1C, set dominates clear) and a registered interrupt.
module flag_reg_sync
    import flag_reg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               STAGES    = 2,
    parameter logic [WIDTH-1:0] INIT      = '0,
    parameter logic [WIDTH-1:0] RISE_MASK = '1,
    parameter logic [WIDTH-1:0] FALL_MASK = '0
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] flag,
    input  logic [WIDTH-1:0] flag_set,
    input  logic [WIDTH-1:0] flag_clr,
    input  logic [WIDTH-1:0] irq_en,
    output logic             irq
);

    if (WIDTH < 1 || WIDTH > FLAG_MAX_WIDTH) begin : g_bad_width
        $error("flag_reg_sync: WIDTH must be in 1..32");
    end

    logic [WIDTH-1:0] q_pre;
    logic [WIDTH-1:0] rise_next;
    logic [WIDTH-1:0] fall_next;
    logic [WIDTH-1:0] ev;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        sync_chain #(
            .STAGES  (STAGES),
            .INIT_BIT(INIT[i])
        ) u_sync (
            .clk  (clk),
            .clr_n(clr_n),
            .d    (d[i]),
            .q    (q[i]),
            .q_pre(q_pre[i])
        );
    end

    // The stage feeding q already holds the next level, so comparing it with q
    // gives edges one cycle early; registering them aligns pulses with q.
    assign rise_next = q_pre & ~q;
    assign fall_next = ~q_pre & q;

    assign ev = WIDTH'(edge_vec(FLAG_MAX_WIDTH'(q), FLAG_MAX_WIDTH'(q_pre),
                                FLAG_MAX_WIDTH'(RISE_MASK)))
              | WIDTH'(edge_vec(FLAG_MAX_WIDTH'(~q), FLAG_MAX_WIDTH'(~q_pre),
                                FLAG_MAX_WIDTH'(FALL_MASK)));

    // Edge pulses, sticky flags (set/event wins over clear) and interrupt.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            rise <= '0;
            fall <= '0;
            flag <= '0;
            irq  <= 1'b0;
        end else begin
            rise <= rise_next;
            fall <= fall_next;
            flag <= (flag & ~flag_clr) | ev | flag_set;
            irq  <= |(flag & irq_en);
        end
    end

endmodule

// File: tb/tb_flag_reg_sync.sv
// Self-checking bench for flag_reg_sync (WIDTH=4, STAGES=2, FALL_MASK=4'b0100).
module tb_flag_reg_sync;

    logic       clk = 1'b0;
    logic       clr_n;
    logic [3:0] d, q, rise, fall, flag, flag_set, flag_clr, irq_en;
    logic       irq;

    always #5 clk = ~clk;

    flag_reg_sync #(
        .WIDTH    (4),
        .STAGES   (2),
        .INIT     (4'b0000),
        .RISE_MASK(4'b1111),
        .FALL_MASK(4'b0100)
    ) dut (
        .clk     (clk),
        .clr_n   (clr_n),
        .d       (d),
        .q       (q),
        .rise    (rise),
        .fall    (fall),
        .flag    (flag),
        .flag_set(flag_set),
        .flag_clr(flag_clr),
        .irq_en  (irq_en),
        .irq     (irq)
    );

    typedef struct {
        logic       clr_n;
        logic [3:0] d, set, clr, en;
        logic [3:0] q, rise, fall, flag;
        logic       irq;
    } vec_t;

    typedef struct {
        int         idx;
        logic [3:0] q, rise, fall, flag;
        logic       irq;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(logic c, logic [3:0] dd, logic [3:0] s, logic [3:0] cl,
                                logic [3:0] e, logic [3:0] eq, logic [3:0] er,
                                logic [3:0] ef, logic [3:0] efl, logic ei);
        vec_t v;
        v.clr_n = c; v.d = dd; v.set = s; v.clr = cl; v.en = e;
        v.q = eq; v.rise = er; v.fall = ef; v.flag = efl; v.irq = ei;
        return v;
    endfunction

    task automatic chk(string nm, int idx, logic [3:0] act, logic [3:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s vec=%0d actual=%b required=%b", nm, idx, act, req);
        end
    endtask

    task automatic apply(vec_t v, int idx);
        exp_t e;
        clr_n = v.clr_n; d = v.d; flag_set = v.set; flag_clr = v.clr; irq_en = v.en;
        e.idx = idx; e.q = v.q; e.rise = v.rise; e.fall = v.fall; e.flag = v.flag; e.irq = v.irq;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        e = sb.pop_front();
        chk("q",    e.idx, q,    e.q);
        chk("rise", e.idx, rise, e.rise);
        chk("fall", e.idx, fall, e.fall);
        chk("flag", e.idx, flag, e.flag);
        chk("irq",  e.idx, {3'b000, irq}, {3'b000, e.irq});
    endtask

    initial begin
        int n;
        clr_n = 1'b0; d = '0; flag_set = '0; flag_clr = '0; irq_en = '0;

        //               clr d     set   clr   en    | q     rise  fall  flag  irq
        // reset held with d high, then release
        vecs.push_back(mk(0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0)); // 0
        vecs.push_back(mk(0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0));
        vecs.push_back(mk(1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0));
        vecs.push_back(mk(1, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'hF, 0));
        vecs.push_back(mk(1, 4'hF, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 0));
        vecs.push_back(mk(1, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 0)); // 5
        // all channels fall: only bit 2 sets its flag
        vecs.push_back(mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 0));
        vecs.push_back(mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h4, 0));
        vecs.push_back(mk(1, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0));
        // d[0] rises, irq follows flag by one edge
        vecs.push_back(mk(1, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 0));
        vecs.push_back(mk(1, 4'h1, 4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h1, 0)); // 10
        vecs.push_back(mk(1, 4'h1, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h1, 1));
        // W1C with no event, irq drops one edge later
        vecs.push_back(mk(1, 4'h1, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 1));
        vecs.push_back(mk(1, 4'h1, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 0));
        // software set, irq_en toggling alone
        vecs.push_back(mk(1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 0));
        vecs.push_back(mk(1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 0)); // 15
        vecs.push_back(mk(1, 4'h1, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h1, 1));
        vecs.push_back(mk(1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 0));
        vecs.push_back(mk(1, 4'h1, 4'h0, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 0));
        // d[1], d[2] rise then fall; only fall[2] is flagged
        vecs.push_back(mk(1, 4'h7, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 0));
        vecs.push_back(mk(1, 4'h7, 4'h0, 4'h0, 4'h0, 4'h7, 4'h6, 4'h0, 4'h6, 0)); // 20
        vecs.push_back(mk(1, 4'h7, 4'h0, 4'h6, 4'h0, 4'h7, 4'h0, 4'h0, 4'h0, 0));
        vecs.push_back(mk(1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h7, 4'h0, 4'h0, 4'h0, 0));
        vecs.push_back(mk(1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h6, 4'h4, 0));
        vecs.push_back(mk(1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h4, 0));
        vecs.push_back(mk(1, 4'h1, 4'h0, 4'h4, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 0)); // 25
        // rise[3] coinciding with clr[3]; set with clr on bit 1
        vecs.push_back(mk(1, 4'h9, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 0));
        vecs.push_back(mk(1, 4'h9, 4'h0, 4'h8, 4'h0, 4'h9, 4'h8, 4'h0, 4'h8, 0));
        vecs.push_back(mk(1, 4'h9, 4'h2, 4'h2, 4'h0, 4'h9, 4'h0, 4'h0, 4'hA, 0));
        vecs.push_back(mk(1, 4'h9, 4'h0, 4'hA, 4'h0, 4'h9, 4'h0, 4'h0, 4'h0, 0));
        // d[0] toggling every cycle
        vecs.push_back(mk(1, 4'h8, 4'h0, 4'h0, 4'h0, 4'h9, 4'h0, 4'h0, 4'h0, 0)); // 30
        vecs.push_back(mk(1, 4'h9, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0, 4'h1, 4'h0, 0));
        vecs.push_back(mk(1, 4'h8, 4'h0, 4'h0, 4'h0, 4'h9, 4'h1, 4'h0, 4'h1, 0));
        vecs.push_back(mk(1, 4'h9, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0, 4'h1, 4'h1, 0));
        vecs.push_back(mk(1, 4'h9, 4'h0, 4'h1, 4'h0, 4'h9, 4'h1, 4'h0, 4'h1, 0));
        vecs.push_back(mk(1, 4'h9, 4'h0, 4'h1, 4'h0, 4'h9, 4'h0, 4'h0, 4'h0, 0)); // 35
        // reset mid-chain with flags and irq high
        vecs.push_back(mk(1, 4'h8, 4'hF, 4'h0, 4'hF, 4'h9, 4'h0, 4'h0, 4'hF, 0));
        vecs.push_back(mk(1, 4'h9, 4'h0, 4'h0, 4'hF, 4'h8, 4'h0, 4'h1, 4'hF, 1));
        vecs.push_back(mk(0, 4'h9, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 0));
        vecs.push_back(mk(1, 4'h9, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 0));
        vecs.push_back(mk(1, 4'h9, 4'h0, 4'h0, 4'hF, 4'h9, 4'h9, 4'h0, 4'h9, 0)); // 40
        vecs.push_back(mk(1, 4'h9, 4'h0, 4'h0, 4'hF, 4'h9, 4'h0, 4'h0, 4'h9, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
            @(posedge clk);
            @(negedge clk);
            check_out();
        end

        // Latency of a falling d[3]: fall[3] must appear exactly two edges later.
        clr_n = 1'b1; d = 4'h1; flag_set = '0; flag_clr = '0; irq_en = '0;
        n = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (fall[3] === 1'b1) begin
                n = k;
                break;
            end
        end
        chk("fall3_latency", 100, 4'(n), 4'd2);
        chk("q_at_fall3", 101, q, 4'h1);
        chk("flag_no_fall3", 102, flag, 4'h9);
        @(posedge clk);
        @(negedge clk);
        chk("fall3_one_cycle", 103, fall, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
